// File: rtl/spi_byte_fifo_pkg.sv
// Shared types for the SPI byte FIFO stage: dispatch FSM encoding, overflow bit
// indices and the default FIFO depth.
package spi_byte_fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;

  localparam int OVF_TX = 0;
  localparam int OVF_RX = 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_CAPTURE    = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/spi_byte_fifo_if.sv
// Bus-side and core-side signal bundle of spi_byte_fifo. irq_o exists only when
// SPI_FIFO_IRQ_EN is defined.
interface spi_byte_fifo_if #(
  parameter int DEPTH = spi_byte_fifo_pkg::DEFAULT_DEPTH
);
  import spi_byte_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);

  // Handshake semantics: tx_push_i / rx_pop_i / core_tx_we_o are one-cycle strobes
  // with no ready return; a strobe counts on the clock edge it is high. A push
  // meets back-pressure only through tx_full_o (a push while full is dropped and
  // flagged), a pop on empty is ignored, and core_txdata_o is valid only in the
  // cycle core_tx_we_o is high.
  logic [7:0]  tx_wdata_i;
  logic        tx_push_i;
  logic        tx_full_o;
  logic        tx_empty_o;
  logic [AW:0] tx_level_o;
  logic [7:0]  rx_rdata_o;
  logic        rx_pop_i;
  logic        rx_empty_o;
  logic        rx_full_o;
  logic [AW:0] rx_level_o;
  logic [1:0]  ovf_o;
  logic        ovf_clr_i;
  logic        flush_i;
  logic        spi_en_i;
  logic        core_busy_i;
  logic        core_tx_we_o;
  logic [7:0]  core_txdata_o;
  logic [7:0]  core_rxdata_i;
  fsm_state_e  fsm_state_o;
`ifdef SPI_FIFO_IRQ_EN
  logic        irq_o;
`endif

  modport slave (
    input  tx_wdata_i, tx_push_i, rx_pop_i, ovf_clr_i, flush_i, spi_en_i,
    input  core_busy_i, core_rxdata_i,
    output tx_full_o, tx_empty_o, tx_level_o, rx_rdata_o, rx_empty_o, rx_full_o,
    output rx_level_o, ovf_o, core_tx_we_o, core_txdata_o, fsm_state_o
`ifdef SPI_FIFO_IRQ_EN
    , output irq_o
`endif
  );

  modport master (
    output tx_wdata_i, tx_push_i, rx_pop_i, ovf_clr_i, flush_i, spi_en_i,
    output core_busy_i, core_rxdata_i,
    input  tx_full_o, tx_empty_o, tx_level_o, rx_rdata_o, rx_empty_o, rx_full_o,
    input  rx_level_o, ovf_o, core_tx_we_o, core_txdata_o, fsm_state_o
`ifdef SPI_FIFO_IRQ_EN
    , input irq_o
`endif
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// 8-bit synchronous FIFO with first-word-fall-through read, level/full/empty and
// a synchronous flush; drop_o pulses when a push is refused because of full.
module spi_sync_fifo #(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [7:0]  wdata_i,
  input  logic        pop_i,
  output logic [7:0]  rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o,
  output logic        drop_o
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign level_o = wptr_q - rptr_q;
  assign empty_o = (level_o == '0);
  assign full_o  = (level_o == (AW + 1)'(DEPTH));
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a push at full is still accepted.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    drop_o = 1'b0;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q[AW-1:0]] = wdata_i;
        wptr_d                = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      drop_o = push_i && !do_push;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/spi_byte_fifo.sv
// Byte-buffering stage between the SPI register file and the SPI shift core.
// Optional feature macro: SPI_FIFO_IRQ_EN (adds registered irq_o and TX_WM/RX_WM).
module spi_byte_fifo
  import spi_byte_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
`ifdef SPI_FIFO_IRQ_EN
  ,
  parameter int TX_WM = 2,
  parameter int RX_WM = 1
`endif
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  spi_byte_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  fsm_state_e  state_q, state_d;
  logic [1:0]  ovf_q, ovf_d;

  logic        tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0]  tx_head;
  logic [AW:0] tx_level;
  logic        rx_push, rx_full, rx_empty, rx_drop;
  logic [7:0]  rx_head;
  logic [AW:0] rx_level;

  assign tx_pop  = (state_q == ST_LAUNCH);
  assign rx_push = (state_q == ST_CAPTURE);

  spi_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .flush_i (bus.flush_i),
    .push_i  (bus.tx_push_i),
    .wdata_i (bus.tx_wdata_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level),
    .drop_o  (tx_drop)
  );

  spi_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .flush_i (bus.flush_i),
    .push_i  (rx_push),
    .wdata_i (bus.core_rxdata_i),
    .pop_i   (bus.rx_pop_i),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level),
    .drop_o  (rx_drop)
  );

  // No launch while a flush is pending: the head byte would vanish under LAUNCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty && bus.spi_en_i && !bus.core_busy_i && !bus.flush_i) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH:     state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (bus.core_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (!bus.spi_en_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.core_busy_i) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE:    state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Clear first, then OR in new events so a simultaneous overflow survives.
  always_comb begin
    ovf_d         = bus.ovf_clr_i ? 2'b00 : ovf_q;
    ovf_d[OVF_TX] = ovf_d[OVF_TX] | tx_drop;
    ovf_d[OVF_RX] = ovf_d[OVF_RX] | rx_drop;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ovf_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SPI_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (tx_level <= (AW + 1)'(TX_WM)) || (rx_level >= (AW + 1)'(RX_WM)) || (|ovf_q);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq_o = irq_q;
`endif

  assign bus.tx_full_o     = tx_full;
  assign bus.tx_empty_o    = tx_empty;
  assign bus.tx_level_o    = tx_level;
  assign bus.rx_rdata_o    = rx_head;
  assign bus.rx_empty_o    = rx_empty;
  assign bus.rx_full_o     = rx_full;
  assign bus.rx_level_o    = rx_level;
  assign bus.ovf_o         = ovf_q;
  assign bus.core_tx_we_o  = tx_pop;
  assign bus.core_txdata_o = tx_pop ? tx_head : 8'h00;
  assign bus.fsm_state_o   = state_q;

endmodule

// File: tb/tb_spi_byte_fifo.sv
// Self-checking bench for spi_byte_fifo: reset state, TX fill table, latency,
// loopback ordering, RX overflow, flush, abort, reset mid-transfer, random traffic.
module tb_spi_byte_fifo;
  import spi_byte_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  spi_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

  spi_byte_fifo #(.DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic       core_auto = 1'b0;
  logic       auto_busy = 1'b0;
  logic [7:0] auto_rx   = 8'h00;
  logic       man_busy  = 1'b0;
  logic [7:0] man_rx    = 8'h00;
  logic [7:0] core_xor  = 8'h00;
  logic [7:0] launch_q[$];
  logic       launch_while_busy = 1'b0;

  assign bus.core_busy_i   = core_auto ? auto_busy : man_busy;
  assign bus.core_rxdata_i = core_auto ? auto_rx : man_rx;

  always @(negedge clk) begin
    if (bus.core_tx_we_o && bus.core_busy_i) launch_while_busy = 1'b1;
  end

  initial begin : core_model
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (core_auto && bus.core_tx_we_o) begin
        b = bus.core_txdata_o;
        launch_q.push_back(b);
        repeat ($urandom_range(1, 2)) @(negedge clk);
        auto_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        auto_rx   = b ^ core_xor;
        auto_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.tx_push_i = 1'b0;
    bus.rx_pop_i  = 1'b0;
    bus.ovf_clr_i = 1'b0;
    bus.flush_i   = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.tx_wdata_i = d;
    bus.tx_push_i  = 1'b1;
    @(negedge clk);
    bus.tx_push_i  = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk(name, bus.rx_rdata_o, exp);
    bus.rx_pop_i = 1'b1;
    @(negedge clk);
    bus.rx_pop_i = 1'b0;
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!bus.core_tx_we_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.core_tx_we_o, 1);
  endtask

  // Called one cycle after the launch pulse.
  task automatic manual_xfer(input logic [7:0] rxb);
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    man_rx   = rxb;
    man_busy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       clr;
    logic       flush;
    logic [3:0] exp_level;
    logic       exp_full;
    logic       exp_empty;
    logic [1:0] exp_ovf;
  } vec_t;

  vec_t       vecs[15];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  initial begin : main
    logic [7:0] b, e;
    int n;

    // TX fill table (spi_en_i low, so nothing dispatches)
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{push: 1'b1, data: 8'(8'h10 + i), clr: 1'b0, flush: 1'b0,
                  exp_level: 4'(i + 1), exp_full: (i == 7), exp_empty: 1'b0, exp_ovf: 2'b00};
    end
    vecs[8]  = '{1'b1, 8'h99, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 2'b01};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 2'b00};
    vecs[10] = '{1'b1, 8'h98, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 2'b01};
    vecs[11] = '{1'b1, 8'h97, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 2'b01};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00};
    vecs[13] = '{1'b1, 8'h42, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 2'b00};

    // ---------------- reset ----------------
    drive_idle();
    bus.tx_wdata_i = 8'h00;
    bus.spi_en_i   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_full", bus.tx_full_o, 0);
    chk("rst_tx_empty", bus.tx_empty_o, 1);
    chk("rst_tx_level", bus.tx_level_o, 0);
    chk("rst_rx_rdata", bus.rx_rdata_o, 0);
    chk("rst_rx_empty", bus.rx_empty_o, 1);
    chk("rst_rx_full", bus.rx_full_o, 0);
    chk("rst_rx_level", bus.rx_level_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);
    chk("rst_we", bus.core_tx_we_o, 0);
    chk("rst_txdata", bus.core_txdata_o, 0);
    chk("rst_state", 32'(bus.fsm_state_o), 32'(ST_IDLE));

    bus.rx_pop_i = 1'b1;
    @(negedge clk);
    bus.rx_pop_i = 1'b0;
    chk("pop_empty_level", bus.rx_level_o, 0);
    chk("pop_empty_ovf", bus.ovf_o, 0);

    // ---------------- TX fill table ----------------
    foreach (vecs[i]) begin
      bus.tx_push_i  = vecs[i].push;
      bus.tx_wdata_i = vecs[i].data;
      bus.ovf_clr_i  = vecs[i].clr;
      bus.flush_i    = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("tbl%0d_level", i), bus.tx_level_o, vecs[i].exp_level);
      chk($sformatf("tbl%0d_full", i), bus.tx_full_o, vecs[i].exp_full);
      chk($sformatf("tbl%0d_empty", i), bus.tx_empty_o, vecs[i].exp_empty);
      chk($sformatf("tbl%0d_ovf", i), bus.ovf_o, vecs[i].exp_ovf);
    end
    drive_idle();

    // ---------------- single byte latency ----------------
    bus.spi_en_i = 1'b1;
    @(negedge clk);
    bus.tx_wdata_i = 8'hA5;
    bus.tx_push_i  = 1'b1;
    @(negedge clk);                       // cycle N+1
    bus.tx_push_i  = 1'b0;
    chk("lat_we_n1", bus.core_tx_we_o, 0);
    chk("lat_level_n1", bus.tx_level_o, 1);
    @(negedge clk);                       // cycle N+2
    chk("lat_we_n2", bus.core_tx_we_o, 1);
    chk("lat_data_n2", bus.core_txdata_o, 8'hA5);
    @(negedge clk);
    chk("lat_we_n3", bus.core_tx_we_o, 0);
    chk("lat_tx_empty", bus.tx_empty_o, 1);
    chk("lat_state_ws", 32'(bus.fsm_state_o), 32'(ST_WAIT_START));
    man_busy = 1'b1;
    @(negedge clk);
    chk("lat_state_wd", 32'(bus.fsm_state_o), 32'(ST_WAIT_DONE));
    man_rx   = 8'h5A;
    man_busy = 1'b0;
    @(negedge clk);
    chk("lat_rx_empty_1", bus.rx_empty_o, 1);
    @(negedge clk);
    chk("lat_rx_data_2", bus.rx_rdata_o, 8'h5A);
    chk("lat_rx_level_2", bus.rx_level_o, 1);
    pop_check("lat_rx_pop", 8'h5A);
    chk("lat_rx_empty_after", bus.rx_empty_o, 1);
    chk("lat_rx_zero_after", bus.rx_rdata_o, 0);

    // ---------------- loopback ordering ----------------
    core_xor  = 8'h00;
    core_auto = 1'b1;
    launch_q.delete();
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    n = 0;
    while (!(launch_q.size() == 4 && bus.fsm_state_o == ST_IDLE) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("loop_launches", launch_q.size(), 4);
    for (int i = 1; i <= 4; i++) begin
      b = (launch_q.size() > 0) ? launch_q.pop_front() : 8'hFF;
      chk($sformatf("loop_launch%0d", i), b, 8'(i));
    end
    chk("loop_rx_level", bus.rx_level_o, 4);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("loop_rx%0d", i), 8'(i));
    chk("loop_no_busy_launch", launch_while_busy, 0);

    // ---------------- RX overflow ----------------
    core_xor = 8'hFF;
    for (int i = 0; i < 9; i++) push_byte(8'(8'hC0 + i));
    n = 0;
    while (!(launch_q.size() == 9 && bus.fsm_state_o == ST_IDLE) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("rxovf_launches", launch_q.size(), 9);
    launch_q.delete();
    chk("rxovf_full", bus.rx_full_o, 1);
    chk("rxovf_level", bus.rx_level_o, 8);
    chk("rxovf_flags", bus.ovf_o, 2'b10);
    for (int i = 0; i < 8; i++) pop_check($sformatf("rxovf_rx%0d", i), 8'(8'hC0 + i) ^ 8'hFF);
    chk("rxovf_empty_after", bus.rx_empty_o, 1);
    bus.ovf_clr_i = 1'b1;
    @(negedge clk);
    bus.ovf_clr_i = 1'b0;
    chk("rxovf_clr", bus.ovf_o, 0);
    core_auto = 1'b0;

    // ---------------- flush mid-transfer ----------------
    bus.spi_en_i = 1'b0;
    push_byte(8'hD1);
    push_byte(8'hD2);
    push_byte(8'hD3);
    bus.spi_en_i = 1'b1;
    wait_we("flush_launch");
    chk("flush_launch_data", bus.core_txdata_o, 8'hD1);
    @(negedge clk);
    chk("flush_pre_level", bus.tx_level_o, 2);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_tx_level", bus.tx_level_o, 0);
    chk("flush_tx_empty", bus.tx_empty_o, 1);
    chk("flush_state_kept", 32'(bus.fsm_state_o), 32'(ST_WAIT_START));
    manual_xfer(8'h3C);
    chk("flush_rx_level", bus.rx_level_o, 1);
    chk("flush_state_idle", 32'(bus.fsm_state_o), 32'(ST_IDLE));
    pop_check("flush_rx_data", 8'h3C);

    // ---------------- spi_en drop in WAIT_START ----------------
    bus.spi_en_i = 1'b0;
    push_byte(8'hE1);
    bus.spi_en_i = 1'b1;
    wait_we("abort_launch");
    @(negedge clk);
    bus.spi_en_i = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(bus.fsm_state_o), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    chk("abort_rx_level", bus.rx_level_o, 0);
    chk("abort_tx_level", bus.tx_level_o, 0);

    // ---------------- reset mid-transfer ----------------
    push_byte(8'hE2);
    push_byte(8'hE3);
    bus.spi_en_i = 1'b1;
    wait_we("rstmid_launch");
    @(negedge clk);
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_state_wd", 32'(bus.fsm_state_o), 32'(ST_WAIT_DONE));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_state", 32'(bus.fsm_state_o), 32'(ST_IDLE));
    chk("rstmid_tx_level", bus.tx_level_o, 0);
    @(negedge clk);
    rst          = 1'b0;
    man_busy     = 1'b0;
    bus.spi_en_i = 1'b0;
    @(negedge clk);
    chk("rstmid_we", bus.core_tx_we_o, 0);
    chk("rstmid_tx_empty", bus.tx_empty_o, 1);

    // ---------------- random traffic vs. queue model ----------------
    core_xor  = 8'h5A;
    core_auto = 1'b1;
    launch_q.delete();
    launch_while_busy = 1'b0;
    bus.spi_en_i = 1'b1;
    for (int cyc = 0; cyc < 3000 && (cyc < 500 || exp_tx.size() > 0 || exp_rx.size() > 0); cyc++) begin
      while (launch_q.size() > 0) begin
        b = launch_q.pop_front();
        if (exp_tx.size() == 0) begin
          chk("rnd_launch_unexpected", b, 32'hFFFF_FFFF);
        end else begin
          e = exp_tx.pop_front();
          chk("rnd_launch", b, e);
          exp_rx.push_back(e ^ 8'h5A);
        end
      end
      bus.tx_push_i = 1'b0;
      bus.rx_pop_i  = 1'b0;
      if (cyc < 500 && $urandom_range(0, 2) == 0 && !bus.tx_full_o) begin
        bus.tx_wdata_i = 8'($urandom_range(0, 255));
        bus.tx_push_i  = 1'b1;
        exp_tx.push_back(bus.tx_wdata_i);
      end
      if ($urandom_range(0, 1) == 1 && !bus.rx_empty_o) begin
        if (exp_rx.size() == 0) begin
          chk("rnd_rx_unexpected", bus.rx_rdata_o, 32'hFFFF_FFFF);
        end else begin
          chk("rnd_rx", bus.rx_rdata_o, exp_rx.pop_front());
        end
        bus.rx_pop_i = 1'b1;
      end
      @(negedge clk);
    end
    drive_idle();
    repeat (4) @(negedge clk);
    chk("rnd_tx_left", exp_tx.size(), 0);
    chk("rnd_rx_left", exp_rx.size(), 0);
    chk("rnd_tx_level", bus.tx_level_o, 0);
    chk("rnd_rx_level", bus.rx_level_o, 0);
    chk("rnd_ovf", bus.ovf_o, 0);
    chk("rnd_state", 32'(bus.fsm_state_o), 32'(ST_IDLE));
    chk("rnd_no_busy_launch", launch_while_busy, 0);
    core_auto = 1'b0;

`ifdef SPI_FIFO_IRQ_EN
    // ---------------- interrupt ----------------
    bus.spi_en_i = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i));
    repeat (2) @(negedge clk);
    chk("irq_quiet", bus.irq_o, 0);
    bus.spi_en_i = 1'b1;
    wait_we("irq_launch");
    @(negedge clk);
    bus.spi_en_i = 1'b0;
    manual_xfer(8'h77);
    @(negedge clk);
    chk("irq_rx_set", bus.irq_o, 1);
    pop_check("irq_rx_data", 8'h77);
    @(negedge clk);
    chk("irq_rx_clear", bus.irq_o, 0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
